// File: rtl/pps_timebase_pkg.sv
// Shared types and default timing constants for the 1PPS timebase controller.
package pps_timebase_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_e;

  localparam int unsigned DEF_NOMINAL_PERIOD = 250_000_000;
  localparam int unsigned DEF_TOL            = 2500;

endpackage

// File: rtl/pps_timebase_ctrl_sync.sv
// Brings the asynchronous 1PPS into the clock domain: two-flop synchronizer
// followed by a registered rising-edge detect (edge_o is a one-cycle pulse).
module pps_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pps_i,
  output logic edge_o
);

  logic meta_q, sync_q, prev_q, edge_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta_q <= pps_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= sync_q & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/pps_timebase_ctrl.sv
// Qualifies 1PPS edges, locks to them and drives the one-cycle counter_reset
// for the elapsed-time counters, free-running synthetic resets on PPS loss.
module pps_timebase_ctrl
  import pps_timebase_pkg::*;
#(
  parameter int unsigned NOMINAL_PERIOD = DEF_NOMINAL_PERIOD,
  parameter int unsigned TOL            = DEF_TOL,
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned MAX_HOLDOVER   = 16,
  parameter int unsigned PERIOD_W       = 29
) (
  input  logic                clk_250,
  input  logic                reset,
  input  logic                one_pps,
  input  logic                enable,
  input  logic                holdover_en,
  output logic                counter_reset,
  output logic                locked,
  output logic                holdover,
  output logic [1:0]          state,
  output logic [PERIOD_W-1:0] period,
  output logic [31:0]         pps_count,
  output logic [15:0]         err_count
);

  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned HW = $clog2(MAX_HOLDOVER + 1);

  // One extra bit so cnt+1 never wraps in the window compares.
  localparam logic [PERIOD_W:0]   NOM_C   = (PERIOD_W+1)'(NOMINAL_PERIOD);
  localparam logic [PERIOD_W:0]   LO_C    = (PERIOD_W+1)'(NOMINAL_PERIOD - TOL);
  localparam logic [PERIOD_W:0]   HI_C    = (PERIOD_W+1)'(NOMINAL_PERIOD + TOL);
  localparam logic [PERIOD_W:0]   EXT_ONE = (PERIOD_W+1)'(1);
  localparam logic [PERIOD_W-1:0] TOL_C   = PERIOD_W'(TOL);
  localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
  localparam logic [GW-1:0]       GR_ONE  = GW'(1);
  localparam logic [GW-1:0]       GR_LOCK = GW'(LOCK_COUNT);
  localparam logic [HW-1:0]       HO_ONE  = HW'(1);
  localparam logic [HW-1:0]       HO_MAX  = HW'(MAX_HOLDOVER);

  pps_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]       good_run_q, good_run_d;
  logic [HW-1:0]       ho_q, ho_d;
  logic                first_q, first_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [31:0]         pps_q, pps_d;
  logic [15:0]         err_q, err_d;
  logic                pulse_q, pulse;

  logic                edge_w;
  logic [PERIOD_W:0]   cnt_inc;
  logic [PERIOD_W-1:0] meas;
  logic                early, in_win, err_inc, pulse_req, load_tol;

  pps_edge_sync u_sync (
    .clk_i  (clk_250),
    .rst_i  (reset),
    .pps_i  (one_pps),
    .edge_o (edge_w)
  );

  assign cnt_inc = {1'b0, cnt_q} + EXT_ONE;
  assign meas    = cnt_inc[PERIOD_W] ? '1 : cnt_inc[PERIOD_W-1:0];
  assign early   = cnt_inc < LO_C;
  assign in_win  = !early && (cnt_inc <= HI_C);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
    good_run_d = good_run_q;
    first_d    = first_q;
    ho_d       = ho_q;
    period_d   = period_q;
    pps_d      = pps_q;
    err_inc    = 1'b0;
    pulse_req  = 1'b0;
    load_tol   = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQUIRE;
          cnt_d      = '0;
          good_run_d = '0;
          first_d    = 1'b1;
        end
        ST_ACQUIRE: if (edge_w) begin
          pulse_req = 1'b1;
          if (first_q) begin
            first_d = 1'b0;
          end else if (in_win) begin
            good_run_d = good_run_q + GR_ONE;
            period_d   = meas;
            if (good_run_q + GR_ONE == GR_LOCK) state_d = ST_LOCKED;
          end else begin
            good_run_d = '0;
            err_inc    = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (edge_w) begin
            if (early) begin
              err_inc = 1'b1;
            end else begin
              pulse_req = 1'b1;
              pps_d     = pps_q + 32'd1;
              period_d  = meas;
            end
          end else if (cnt_inc == HI_C) begin
            err_inc = 1'b1;
            if (holdover_en) begin
              // Entry pulse is TOL late, so preload cnt to keep the nominal phase.
              state_d   = ST_HOLDOVER;
              pulse_req = 1'b1;
              load_tol  = 1'b1;
              ho_d      = HO_ONE;
            end else begin
              state_d    = ST_ACQUIRE;
              first_d    = 1'b1;
              good_run_d = '0;
            end
          end
        end
        ST_HOLDOVER: begin
          if (edge_w && (!early || cnt_q < TOL_C)) begin
            state_d   = ST_LOCKED;
            pulse_req = 1'b1;
            pps_d     = pps_q + 32'd1;
            ho_d      = '0;
          end else if (edge_w) begin
            state_d    = ST_ACQUIRE;
            err_inc    = 1'b1;
            first_d    = 1'b1;
            good_run_d = '0;
            ho_d       = '0;
          end else if (cnt_inc == NOM_C) begin
            pulse_req = 1'b1;
            ho_d      = ho_q + HO_ONE;
            if (ho_q + HO_ONE == HO_MAX) begin
              state_d    = ST_ACQUIRE;
              first_d    = 1'b1;
              good_run_d = '0;
              ho_d       = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // An edge landing right after a synthetic pulse is still honoured, but
    // never produces a back-to-back reset.
    pulse = pulse_req & ~pulse_q;
    if (pulse) cnt_d = load_tol ? TOL_C : '0;
    err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
  end

  always_ff @(posedge clk_250 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      good_run_q <= '0;
      ho_q       <= '0;
      first_q    <= 1'b0;
      period_q   <= '0;
      pps_q      <= '0;
      err_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_run_q <= good_run_d;
      ho_q       <= ho_d;
      first_q    <= first_d;
      period_q   <= period_d;
      pps_q      <= pps_d;
      err_q      <= err_d;
      pulse_q    <= pulse;
    end
  end

  assign counter_reset = pulse;
  assign locked        = (state_q == ST_LOCKED);
  assign holdover      = (state_q == ST_HOLDOVER);
  assign state         = state_q;
  assign period        = period_q;
  assign pps_count     = pps_q;
  assign err_count     = err_q;

endmodule

// File: tb/tb_pps_timebase_ctrl.sv
// Directed bench for pps_timebase_ctrl with small timing parameters; counter_reset
// pulses are scoreboarded by cycle number against expectations pushed with the stimulus.
module tb_pps_timebase_ctrl;

  localparam int NOM = 100;
  localparam int TOL = 2;
  localparam int PW  = 29;

  logic          clk_250 = 1'b0;
  logic          reset, one_pps, enable, holdover_en;
  logic          counter_reset, locked, holdover;
  logic [1:0]    state;
  logic [PW-1:0] period;
  logic [31:0]   pps_count;
  logic [15:0]   err_count;

  pps_timebase_ctrl #(
    .NOMINAL_PERIOD (NOM),
    .TOL            (TOL),
    .LOCK_COUNT     (3),
    .MAX_HOLDOVER   (4),
    .PERIOD_W       (PW)
  ) dut (
    .clk_250       (clk_250),
    .reset         (reset),
    .one_pps       (one_pps),
    .enable        (enable),
    .holdover_en   (holdover_en),
    .counter_reset (counter_reset),
    .locked        (locked),
    .holdover      (holdover),
    .state         (state),
    .period        (period),
    .pps_count     (pps_count),
    .err_count     (err_count)
  );

  always #5 clk_250 = ~clk_250;

  int cyc = 0;
  always @(posedge clk_250) cyc <= cyc + 1;

  // Monitor only appends; the main block reads with its own index.
  int obs_q[$];
  int exp_q[$];
  always @(negedge clk_250) if (counter_reset === 1'b1) obs_q.push_back(cyc);

  int n_assert = 0;
  int n_fail   = 0;
  int exp_rd   = 0;
  int obs_rd   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_pulses(input string tag);
    while (exp_rd < exp_q.size() || obs_rd < obs_q.size()) begin
      int e, o;
      e = -1;
      o = -1;
      if (exp_rd < exp_q.size()) begin e = exp_q[exp_rd]; exp_rd++; end
      if (obs_rd < obs_q.size()) begin o = obs_q[obs_rd]; obs_rd++; end
      chk(tag, 64'(o), 64'(e));
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk_250);
      #1;
    end
  endtask

  // Raise one_pps just after edge t; a pulse, if any, is due 3 cycles later.
  task automatic pps(input int t, input int w, input bit expp);
    wait_cyc(t);
    one_pps = 1'b1;
    if (expp) exp_q.push_back(t + 3);
    repeat (w) @(posedge clk_250);
    #1;
    one_pps = 1'b0;
  endtask

  initial begin
    int b, c, d, f;
    reset = 1'b1; one_pps = 1'b0; enable = 1'b0; holdover_en = 1'b1;
    repeat (3) @(posedge clk_250);
    #1;
    chk("rst_state", state, 0);
    chk("rst_creset", counter_reset, 0);
    chk("rst_locked", locked, 0);
    chk("rst_holdover", holdover, 0);
    chk("rst_period", period, 0);
    chk("rst_pps", pps_count, 0);
    chk("rst_err", err_count, 0);

    reset = 1'b0; enable = 1'b1;
    b = cyc + 10;
    wait_cyc(b - 5);
    chk("acq_state", state, 1);

    // Acquire and lock on four edges 100 cycles apart.
    for (int i = 0; i < 4; i++) pps(b + 100 * i, 10, 1'b1);
    wait_cyc(b + 305);
    check_pulses("acq_pulse");
    chk("lock_locked", locked, 1);
    chk("lock_state", state, 2);
    chk("lock_period", period, 100);
    chk("lock_pps", pps_count, 0);
    chk("lock_err", err_count, 0);
    pps(b + 400, 10, 1'b1);
    chk("pps1", pps_count, 1);

    // Window edges 98 and 102 accepted, 97 rejected as glitch.
    pps(b + 498, 10, 1'b1);
    chk("p98_period", period, 98);
    chk("p98_pps", pps_count, 2);
    pps(b + 600, 10, 1'b1);
    chk("p102_period", period, 102);
    chk("p102_pps", pps_count, 3);
    pps(b + 697, 1, 1'b0);
    wait_cyc(b + 701);
    chk("glitch_err", err_count, 1);
    chk("glitch_state", state, 2);
    check_pulses("locked_pulse");

    // PPS lost with holdover: entry pulse at +102, then every 100, four in all.
    exp_q.push_back(b + 705);
    exp_q.push_back(b + 803);
    exp_q.push_back(b + 903);
    exp_q.push_back(b + 1003);
    wait_cyc(b + 706);
    chk("ho_state", state, 3);
    chk("ho_flag", holdover, 1);
    chk("ho_err", err_count, 2);
    wait_cyc(b + 1005);
    check_pulses("ho_pulse");
    chk("ho_exit_state", state, 1);

    // Relock, then lose PPS without holdover.
    c = b + 1100;
    for (int i = 0; i < 4; i++) pps(c + 100 * i, 10, 1'b1);
    wait_cyc(c + 305);
    chk("relock_state", state, 2);
    chk("relock_pps", pps_count, 3);
    holdover_en = 1'b0;
    wait_cyc(c + 407);
    chk("noho_state", state, 1);
    chk("noho_err", err_count, 3);
    check_pulses("noho_pulse");

    // Holdover re-entry: real edge coincident with synthetic, then one cycle late.
    holdover_en = 1'b1;
    d = c + 500;
    for (int i = 0; i < 4; i++) pps(d + 100 * i, 10, 1'b1);
    wait_cyc(d + 305);
    chk("lock3_state", state, 2);
    exp_q.push_back(d + 405);
    wait_cyc(d + 406);
    chk("ho2_state", state, 3);
    chk("ho2_err", err_count, 4);
    pps(d + 500, 10, 1'b1);
    chk("coinc_state", state, 2);
    chk("coinc_holdover", holdover, 0);
    check_pulses("coinc_pulse");
    exp_q.push_back(d + 605);
    wait_cyc(d + 606);
    chk("ho3_state", state, 3);
    chk("ho3_err", err_count, 5);
    exp_q.push_back(d + 703);
    pps(d + 701, 10, 1'b0);
    wait_cyc(d + 706);
    chk("late1_state", state, 2);
    check_pulses("late1_pulse");

    // Drop enable mid-LOCKED: IDLE next cycle, status held, no resets.
    wait_cyc(d + 750);
    enable = 1'b0;
    wait_cyc(d + 752);
    chk("dis_state", state, 0);
    chk("dis_err", err_count, 5);
    chk("dis_period", period, 100);
    wait_cyc(d + 820);
    check_pulses("dis_pulse");

    // Relock, then async reset mid-second.
    wait_cyc(d + 850);
    enable = 1'b1;
    f = d + 900;
    for (int i = 0; i < 4; i++) pps(f + 100 * i, 10, 1'b1);
    wait_cyc(f + 305);
    chk("lock4_state", state, 2);
    check_pulses("lock4_pulse");
    wait_cyc(f + 350);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_locked", locked, 0);
    chk("arst_creset", counter_reset, 0);
    chk("arst_pps", pps_count, 0);
    chk("arst_err", err_count, 0);
    chk("arst_period", period, 0);
    enable = 1'b0;
    wait_cyc(f + 360);
    reset = 1'b0;
    wait_cyc(f + 380);
    chk("post_state", state, 0);
    chk("post_holdover", holdover, 0);
    chk("post_err", err_count, 0);
    check_pulses("post_pulse");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
